// File: rtl/wb_bridge_pkg.sv
// Shared definitions for the N-way Wishbone bridge.
//   WB_DW / WB_SELW : upstream data and byte-select widths
//   PORT_IDXW       : width of a port index (supports up to 8 ports)
//   ERR_DATA        : read data returned with every error response
//   state_e         : bridge FSM states
//   STAT_*          : bit positions inside status_o
package wb_bridge_pkg;

    localparam int unsigned WB_DW     = 32;
    localparam int unsigned WB_SELW   = 4;
    localparam int unsigned PORT_IDXW = 3;

    localparam logic [WB_DW-1:0]     ERR_DATA      = 32'hDEAD_BEEF;
    // Reported as last_err_port when no port decoded the address.
    localparam logic [PORT_IDXW-1:0] UNMAPPED_PORT = 3'd7;

    localparam int unsigned STAT_TIMEOUT_BIT  = 7;
    localparam int unsigned STAT_UNMAPPED_BIT = 6;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFwd  = 2'd1,
        StResp = 2'd2
    } state_e;

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational base/mask address decoder.
//   adr_i : upstream byte address
//   hit_o : some port matches adr_i
//   idx_o : index of the lowest-numbered matching port (0 when no hit)
module wb_addr_decode
    import wb_bridge_pkg::*;
#(
    parameter int unsigned           NPORTS = 4,
    parameter logic [32*NPORTS-1:0]  BASES  = {32'h3000_0C00, 32'h3000_0800,
                                               32'h3000_0400, 32'h3000_0000},
    parameter logic [32*NPORTS-1:0]  MASKS  = {4{32'hFFFF_FC00}}
) (
    input  logic [31:0]          adr_i,
    output logic                 hit_o,
    output logic [PORT_IDXW-1:0] idx_o
);

    // Scan from the top down so the lowest matching index is written last.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = int'(NPORTS) - 1; i >= 0; i--) begin
            if ((adr_i & MASKS[i*32 +: 32]) == (BASES[i*32 +: 32] & MASKS[i*32 +: 32])) begin
                hit_o = 1'b1;
                idx_o = PORT_IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/wb_bridge_nway.sv
// N-way Wishbone classic bridge: decodes the upstream address by per-port
// base/mask, registers the request and forwards it to exactly one port.
// Unmapped addresses and missing downstream acks return an error response.
//   wb_clk_i / wb_rst_ni      : clock, async active-low reset
//   wbs_*                     : upstream slave port (ack doubles as error ack)
//   wbm_*                     : per-port downstream master buses, flattened, port 0 in LSBs
//   status_o                  : {timeout_sticky, unmapped_sticky, 3'b0, last_err_port}
module wb_bridge_nway
    import wb_bridge_pkg::*;
#(
    parameter int unsigned          NPORTS  = 4,
    parameter int unsigned          SUB_AW  = 10,
    parameter logic [32*NPORTS-1:0] BASES   = {32'h3000_0C00, 32'h3000_0800,
                                               32'h3000_0400, 32'h3000_0000},
    parameter logic [32*NPORTS-1:0] MASKS   = {4{32'hFFFF_FC00}},
    parameter int unsigned          TIMEOUT = 16
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_ni,
    input  logic                        wbs_stb_i,
    input  logic                        wbs_cyc_i,
    input  logic                        wbs_we_i,
    input  logic [WB_SELW-1:0]          wbs_sel_i,
    input  logic [WB_DW-1:0]            wbs_dat_i,
    input  logic [31:0]                 wbs_adr_i,
    output logic                        wbs_ack_o,
    output logic                        wbs_err_o,
    output logic [WB_DW-1:0]            wbs_dat_o,
    output logic [NPORTS-1:0]           wbm_stb_o,
    output logic [NPORTS-1:0]           wbm_cyc_o,
    output logic [NPORTS-1:0]           wbm_we_o,
    output logic [WB_SELW*NPORTS-1:0]   wbm_sel_o,
    output logic [WB_DW*NPORTS-1:0]     wbm_dat_o,
    output logic [SUB_AW*NPORTS-1:0]    wbm_adr_o,
    input  logic [NPORTS-1:0]           wbm_ack_i,
    input  logic [WB_DW*NPORTS-1:0]     wbm_dat_i,
    output logic [7:0]                  status_o
);

    localparam int unsigned     CntW   = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    state_e                     state_q;
    logic [PORT_IDXW-1:0]       port_q;
    logic [CntW-1:0]            cnt_q;
    logic                       wbs_ack_q;
    logic                       wbs_err_q;
    logic [WB_DW-1:0]           wbs_dat_q;
    logic [NPORTS-1:0]          stb_q;
    logic [NPORTS-1:0]          we_q;
    logic [WB_SELW*NPORTS-1:0]  sel_q;
    logic [WB_DW*NPORTS-1:0]    wdat_q;
    logic [SUB_AW*NPORTS-1:0]   adr_q;
    logic                       to_sticky_q;
    logic                       un_sticky_q;
    logic [PORT_IDXW-1:0]       last_err_q;

    logic                       dec_hit;
    logic [PORT_IDXW-1:0]       dec_idx;
    logic                       req;
    logic                       sel_ack;
    logic [WB_DW-1:0]           sel_rdata;
    logic                       timeout_hit;
    logic                       fwd_exit;

    wb_addr_decode #(
        .NPORTS (NPORTS),
        .BASES  (BASES),
        .MASKS  (MASKS)
    ) u_decode (
        .adr_i  (wbs_adr_i),
        .hit_o  (dec_hit),
        .idx_o  (dec_idx)
    );

    assign req = wbs_cyc_i & wbs_stb_i;

    // Only the selected port's ack/data matter; everything else is ignored.
    always_comb begin
        sel_ack   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < int'(NPORTS); i++) begin
            if (port_q == PORT_IDXW'(i)) begin
                sel_ack   = wbm_ack_i[i];
                sel_rdata = wbm_dat_i[i*WB_DW +: WB_DW];
            end
        end
    end

    assign timeout_hit = (cnt_q == CntMax);
    assign fwd_exit    = (state_q == StFwd) & (~wbs_cyc_i | sel_ack | timeout_hit);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= StIdle;
            port_q      <= '0;
            cnt_q       <= '0;
            wbs_ack_q   <= 1'b0;
            wbs_err_q   <= 1'b0;
            wbs_dat_q   <= '0;
            stb_q       <= '0;
            we_q        <= '0;
            sel_q       <= '0;
            wdat_q      <= '0;
            adr_q       <= '0;
            to_sticky_q <= 1'b0;
            un_sticky_q <= 1'b0;
            last_err_q  <= '0;
        end else begin
            // Upstream response is a single-cycle pulse.
            wbs_ack_q <= 1'b0;
            wbs_err_q <= 1'b0;
            wbs_dat_q <= '0;

            case (state_q)
                StIdle: begin
                    if (req) begin
                        if (dec_hit) begin
                            state_q <= StFwd;
                            port_q  <= dec_idx;
                            cnt_q   <= '0;
                            // Downstream buses are all-zero in IDLE, so only the
                            // selected slice needs loading.
                            for (int i = 0; i < int'(NPORTS); i++) begin
                                if (dec_idx == PORT_IDXW'(i)) begin
                                    stb_q[i]                      <= 1'b1;
                                    we_q[i]                       <= wbs_we_i;
                                    sel_q[i*WB_SELW +: WB_SELW]   <= wbs_sel_i;
                                    wdat_q[i*WB_DW +: WB_DW]      <= wbs_dat_i;
                                    adr_q[i*SUB_AW +: SUB_AW]     <= wbs_adr_i[SUB_AW-1:0];
                                end
                            end
                        end else begin
                            state_q     <= StResp;
                            wbs_ack_q   <= 1'b1;
                            wbs_err_q   <= 1'b1;
                            wbs_dat_q   <= ERR_DATA;
                            un_sticky_q <= 1'b1;
                            last_err_q  <= UNMAPPED_PORT;
                        end
                    end
                end

                StFwd: begin
                    // Priority: master abort, then ack (beats a same-cycle timeout).
                    if (!wbs_cyc_i) begin
                        state_q <= StIdle;
                    end else if (sel_ack) begin
                        state_q   <= StResp;
                        wbs_ack_q <= 1'b1;
                        wbs_dat_q <= (|we_q) ? '0 : sel_rdata;
                    end else if (timeout_hit) begin
                        state_q     <= StResp;
                        wbs_ack_q   <= 1'b1;
                        wbs_err_q   <= 1'b1;
                        wbs_dat_q   <= ERR_DATA;
                        to_sticky_q <= 1'b1;
                        last_err_q  <= port_q;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end

                StResp: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase

            if (fwd_exit) begin
                stb_q  <= '0;
                we_q   <= '0;
                sel_q  <= '0;
                wdat_q <= '0;
                adr_q  <= '0;
            end
        end
    end

    assign wbs_ack_o = wbs_ack_q;
    assign wbs_err_o = wbs_err_q;
    assign wbs_dat_o = wbs_dat_q;
    assign wbm_stb_o = stb_q;
    assign wbm_cyc_o = stb_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_dat_o = wdat_q;
    assign wbm_adr_o = adr_q;

    always_comb begin
        status_o                    = {3'b000, 2'b00, last_err_q};
        status_o[STAT_TIMEOUT_BIT]  = to_sticky_q;
        status_o[STAT_UNMAPPED_BIT] = un_sticky_q;
    end

endmodule

// File: tb/tb_wb_bridge_nway.sv
// Self-checking bench for wb_bridge_nway: directed scenarios plus randomized
// transactions compared against a transaction-level model of the bridge.
module tb_wb_bridge_nway;

    localparam int NP = 4;
    localparam int AW = 10;
    localparam int TO = 16;

    logic              clk;
    logic              rst_n;
    logic              cyc, stb, we;
    logic [3:0]        sel;
    logic [31:0]       dat, adr;
    logic              ack_o, err_o;
    logic [31:0]       dat_o;
    logic [NP-1:0]     m_stb, m_cyc, m_we, m_ack;
    logic [4*NP-1:0]   m_sel;
    logic [32*NP-1:0]  m_dat, m_dati;
    logic [AW*NP-1:0]  m_adr;
    logic [7:0]        status;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_base [NP] = '{32'h3000_0000, 32'h3000_0400, 32'h3000_0800, 32'h3000_0C00};
    logic [31:0] m_mask [NP] = '{32'hFFFF_FC00, 32'hFFFF_FC00, 32'hFFFF_FC00, 32'hFFFF_FC00};
    logic        mdl_to, mdl_un;
    logic [2:0]  mdl_last;

    // Optional request presented during the response cycle (back-to-back)
    logic        nx_valid = 1'b0;
    logic [31:0] nx_adr, nx_dat;
    logic        nx_we;
    logic [3:0]  nx_sel;

    wb_bridge_nway #(
        .NPORTS  (NP),
        .SUB_AW  (AW),
        .BASES   ({32'h3000_0C00, 32'h3000_0800, 32'h3000_0400, 32'h3000_0000}),
        .MASKS   ({4{32'hFFFF_FC00}}),
        .TIMEOUT (TO)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_dat_i (dat),
        .wbs_adr_i (adr),
        .wbs_ack_o (ack_o),
        .wbs_err_o (err_o),
        .wbs_dat_o (dat_o),
        .wbm_stb_o (m_stb),
        .wbm_cyc_o (m_cyc),
        .wbm_we_o  (m_we),
        .wbm_sel_o (m_sel),
        .wbm_dat_o (m_dat),
        .wbm_adr_o (m_adr),
        .wbm_ack_i (m_ack),
        .wbm_dat_i (m_dati),
        .status_o  (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired act=running exp=finished");
        $fatal(1);
    end

    function automatic bit model_decode(input logic [31:0] a, output int p);
        p = 0;
        for (int i = 0; i < NP; i++) begin
            if ((a & m_mask[i]) == (m_base[i] & m_mask[i])) begin
                p = i;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [7:0] model_status();
        return {mdl_to, mdl_un, 3'b000, mdl_last};
    endfunction

    task automatic idle_inputs();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; dat = '0; adr = '0;
        m_ack = '0; m_dati = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mdl_to = 1'b0; mdl_un = 1'b0; mdl_last = 3'd0;
    endtask

    // Drives one upstream transaction from a negedge with the bridge idle.
    // dly: downstream acks on its dly-th strobe cycle; 0 or >TO means never.
    task automatic run_txn(input logic [31:0] a, input logic w, input logic [3:0] s,
                           input logic [31:0] wd, input int dly, input logic [31:0] rd,
                           input bit noise, input string tag);
        int          p, resp_cyc;
        bit          hit, exp_err, tmo;
        logic [31:0] exp_dat;
        logic [NP-1:0]    e_stb, e_we;
        logic [4*NP-1:0]  e_sel;
        logic [32*NP-1:0] e_dat;
        logic [AW*NP-1:0] e_adr;
        hit = model_decode(a, p);
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; dat = wd; adr = a;
        tmo = 1'b0;
        if (!hit) begin
            resp_cyc = 1; exp_err = 1'b1; exp_dat = 32'hDEAD_BEEF;
        end else if (dly >= 1 && dly <= TO) begin
            resp_cyc = dly + 1; exp_err = 1'b0; exp_dat = w ? 32'h0 : rd;
        end else begin
            resp_cyc = TO + 1; exp_err = 1'b1; exp_dat = 32'hDEAD_BEEF; tmo = 1'b1;
        end
        e_stb = '0; e_we = '0; e_sel = '0; e_dat = '0; e_adr = '0;
        if (hit) begin
            e_stb[p] = 1'b1; e_we[p] = w; e_sel[p*4 +: 4] = s;
            e_dat[p*32 +: 32] = wd; e_adr[p*AW +: AW] = a[AW-1:0];
        end
        for (int c = 1; c <= resp_cyc; c++) begin
            @(posedge clk);
            @(negedge clk);
            m_ack = '0;
            if (c < resp_cyc) begin
                checks++;
                if (m_stb !== e_stb || m_cyc !== e_stb) begin
                    failures++;
                    $display("FAIL %s c%0d stb/cyc act=%b/%b exp=%b", tag, c, m_stb, m_cyc, e_stb);
                end
                checks++;
                if (m_we !== e_we || m_sel !== e_sel) begin
                    failures++;
                    $display("FAIL %s c%0d we/sel act=%b/%h exp=%b/%h", tag, c, m_we, m_sel, e_we, e_sel);
                end
                checks++;
                if (m_dat !== e_dat || m_adr !== e_adr) begin
                    failures++;
                    $display("FAIL %s c%0d dat/adr act=%h/%h exp=%h/%h", tag, c, m_dat, m_adr, e_dat, e_adr);
                end
                checks++;
                if (ack_o !== 1'b0) begin
                    failures++;
                    $display("FAIL %s c%0d early_ack act=%b exp=0", tag, c, ack_o);
                end
                for (int k = 0; k < NP; k++) m_dati[k*32 +: 32] = $urandom;
                if (noise) begin
                    int q;
                    q = $urandom_range(0, NP - 1);
                    if (q != p) m_ack[q] = 1'b1;
                end
                if (c == dly) begin
                    m_ack[p] = 1'b1;
                    m_dati[p*32 +: 32] = rd;
                end
            end else begin
                if (!hit) begin
                    mdl_un = 1'b1; mdl_last = 3'd7;
                end else if (tmo) begin
                    mdl_to = 1'b1; mdl_last = 3'(p);
                end
                checks++;
                if (ack_o !== 1'b1 || err_o !== exp_err) begin
                    failures++;
                    $display("FAIL %s resp ack/err act=%b/%b exp=1/%b", tag, ack_o, err_o, exp_err);
                end
                checks++;
                if (dat_o !== exp_dat) begin
                    failures++;
                    $display("FAIL %s resp dat act=%h exp=%h", tag, dat_o, exp_dat);
                end
                checks++;
                if (m_stb !== '0 || m_cyc !== '0) begin
                    failures++;
                    $display("FAIL %s resp stb act=%b exp=0", tag, m_stb);
                end
                checks++;
                if (status !== model_status()) begin
                    failures++;
                    $display("FAIL %s status act=%h exp=%h", tag, status, model_status());
                end
                if (nx_valid) begin
                    we = nx_we; sel = nx_sel; dat = nx_dat; adr = nx_adr;
                    nx_valid = 1'b0;
                end else begin
                    cyc = 1'b0; stb = 1'b0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ack_o !== 1'b0 || err_o !== 1'b0 || dat_o !== 32'h0 || m_stb !== '0) begin
            failures++;
            $display("FAIL %s post ack/err/dat/stb act=%b/%b/%h/%b exp=0/0/0/0",
                     tag, ack_o, err_o, dat_o, m_stb);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        checks++;
        if ({ack_o, err_o, dat_o} !== '0) begin
            failures++;
            $display("FAIL reset upstream act=%b/%b/%h exp=0", ack_o, err_o, dat_o);
        end
        checks++;
        if ({m_stb, m_cyc, m_we, m_sel, m_dat, m_adr} !== '0) begin
            failures++;
            $display("FAIL reset downstream act=%b/%b exp=0", m_stb, m_cyc);
        end
        checks++;
        if (status !== 8'h00) begin
            failures++;
            $display("FAIL reset status act=%h exp=00", status);
        end
        rst_n = 1'b1;
        mdl_to = 1'b0; mdl_un = 1'b0; mdl_last = 3'd0;
    endtask

    task automatic test_read();
        run_txn(32'h3000_0404, 1'b0, 4'hF, 32'h0, 3, 32'h1234_5678, 1'b0, "read_p1");
    endtask

    task automatic test_write();
        run_txn(32'h3000_0C10, 1'b1, 4'b0011, 32'hA5A5_0001, 2, 32'hFFFF_FFFF, 1'b1, "write_p3");
    endtask

    task automatic test_unmapped();
        run_txn(32'h2000_0000, 1'b0, 4'hF, 32'h0, 1, 32'h0, 1'b0, "unmapped");
        checks++;
        if (status !== 8'h47) begin
            failures++;
            $display("FAIL unmapped_status act=%h exp=47", status);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        run_txn(32'h3000_0820, 1'b0, 4'hF, 32'h0, 0, 32'h0, 1'b1, "timeout_p2");
        run_txn(32'h3000_0008, 1'b0, 4'hF, 32'h0, 2, 32'hCAFE_0001, 1'b0, "after_to");
        checks++;
        if (status !== 8'h82) begin
            failures++;
            $display("FAIL timeout_status act=%h exp=82", status);
        end
        // Ack arriving in the timeout cycle itself must win.
        run_txn(32'h3000_0400, 1'b0, 4'hF, 32'h0, TO, 32'h0BAD_F00D, 1'b0, "ack_at_to");
    endtask

    task automatic test_back_to_back();
        nx_valid = 1'b1; nx_adr = 32'h3000_0C44; nx_we = 1'b1; nx_sel = 4'hC;
        nx_dat = 32'h1111_2222;
        run_txn(32'h3000_0004, 1'b0, 4'hF, 32'h0, 1, 32'h7777_8888, 1'b0, "b2b_a");
        run_txn(32'h3000_0C44, 1'b1, 4'hC, 32'h1111_2222, 1, 32'h0, 1'b0, "b2b_b");
    endtask

    task automatic test_abort();
        logic [7:0] st_exp;
        st_exp = model_status();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_0408; dat = '0;
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (m_stb !== 4'b0010) begin
                failures++;
                $display("FAIL abort_fwd c%0d act=%b exp=0010", c, m_stb);
            end
        end
        cyc = 1'b0; stb = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (m_stb !== '0 || m_cyc !== '0 || ack_o !== 1'b0 || status !== st_exp) begin
                failures++;
                $display("FAIL abort_after c%0d stb/ack/status act=%b/%b/%h exp=0/0/%h",
                         c, m_stb, ack_o, status, st_exp);
            end
        end
        run_txn(32'h3000_0410, 1'b0, 4'hF, 32'h0, 2, 32'h5555_AAAA, 1'b0, "post_abort");
    endtask

    task automatic test_reset_mid();
        run_txn(32'h3000_2000, 1'b0, 4'hF, 32'h0, 1, 32'h0, 1'b0, "pre_rst_unmapped");
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h3000_0830; dat = 32'h9999_0000;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (m_stb !== 4'b0100) begin
            failures++;
            $display("FAIL rst_mid_fwd act=%b exp=0100", m_stb);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ack_o, err_o, dat_o, m_stb, m_cyc, m_we, m_sel, m_dat, m_adr} !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs act=stb %b adr %h exp=0", m_stb, m_adr);
        end
        checks++;
        if (status !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid_status act=%h exp=00", status);
        end
        mdl_to = 1'b0; mdl_un = 1'b0; mdl_last = 3'd0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(32'h3000_0000, 1'b0, 4'hF, 32'h0, 1, 32'h4242_4242, 1'b0, "post_rst");
    endtask

    task automatic test_random();
        logic [31:0] a [40];
        logic [31:0] d [40];
        logic [31:0] rd [40];
        logic        w [40];
        logic [3:0]  s [40];
        int          dl [40];
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0)      a[i] = 32'h3000_1000 | 32'($urandom_range(0, 16'hFFFF));
            else if (r == 1) a[i] = 32'h2000_0000 | 32'($urandom_range(0, 16'hFFFF));
            else             a[i] = 32'h3000_0000 | 32'($urandom_range(0, 4095));
            w[i]  = 1'($urandom_range(0, 1));
            s[i]  = 4'($urandom_range(1, 15));
            d[i]  = $urandom;
            rd[i] = $urandom;
            r = $urandom_range(0, 9);
            if (r == 0)      dl[i] = 0;
            else if (r == 1) dl[i] = TO;
            else if (r == 2) dl[i] = TO + 1;
            else             dl[i] = $urandom_range(1, 5);
        end
        for (int i = 0; i < 40; i++) begin
            if (i + 1 < 40 && $urandom_range(0, 2) == 0) begin
                nx_valid = 1'b1; nx_adr = a[i+1]; nx_we = w[i+1];
                nx_sel = s[i+1]; nx_dat = d[i+1];
            end
            run_txn(a[i], w[i], s[i], d[i], dl[i], rd[i], 1'b1, "rand");
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        mdl_to = 1'b0; mdl_un = 1'b0; mdl_last = 3'd0;
        test_reset();
        @(negedge clk);
        test_read();
        test_write();
        test_unmapped();
        test_timeout();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
